// File: rtl/triangle_pulse_decoder_pkg.sv
// rtl/triangle_pulse_decoder_pkg.sv - shared constants and state types for the pulse decoder
package triangle_pulse_decoder_pkg;

  localparam logic [7:0]  REST_LEVEL = 8'h80;
  localparam int unsigned HMAX_STEPS = 127;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    RESYNC
  } trk_state_e;

  // Producer-side dav_/rfd handshake, reusable by any descriptor producer.
  typedef enum logic [1:0] {
    EMPTY,
    OFFER,
    HELD
  } hs_state_e;

  typedef struct packed {
    logic       s;
    logic [6:0] h;
  } pulse_t;

endpackage

// File: rtl/triangle_pulse_decoder_dav_producer.sv
// rtl/triangle_pulse_decoder_dav_producer.sv - one-entry holding register with dav_/rfd producer handshake
module dav_producer
  import triangle_pulse_decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         rfd,
  output logic         dav_,
  output logic [W-1:0] data_q,
  output logic         busy
);

  hs_state_e    state_q, state_d;
  logic         dav_q, dav_d;
  logic [W-1:0] data_d;
  logic         clear;
  logic         accept;

  always_comb begin
    state_d = state_q;
    dav_d   = dav_q;
    data_d  = data_q;
    // A consumer release on this edge frees the entry in time for a same-edge load.
    clear   = (state_q == HELD) && !rfd;
    busy    = (state_q != EMPTY) && !clear;
    accept  = load && !busy;

    case (state_q)
      EMPTY: ;
      OFFER: begin
        if (rfd) begin
          state_d = HELD;
          dav_d   = 1'b0;
        end
      end
      HELD: begin
        if (!rfd) begin
          state_d = EMPTY;
          dav_d   = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        dav_d   = 1'b1;
      end
    endcase

    if (accept) begin
      data_d  = data;
      state_d = OFFER;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= EMPTY;
      dav_q   <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dav_q   <= dav_d;
      data_q  <= data_d;
    end
  end

  assign dav_ = dav_q;

endmodule

// File: rtl/triangle_pulse_decoder.sv
// rtl/triangle_pulse_decoder.sv - recovers sign and height of triangular pulses and offers them over dav_/rfd
module triangle_pulse_decoder
  import triangle_pulse_decoder_pkg::*;
#(
  parameter logic [7:0]  REST = REST_LEVEL,
  parameter int unsigned HMAX = HMAX_STEPS
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic [7:0] in,
  output logic       s,
  output logic [6:0] h,
  output logic       dav_,
  input  logic       rfd,
  output logic       err
);

  localparam logic [7:0] HMAX_C = 8'(HMAX);

  trk_state_e state_q, state_d;
  logic       sgn_q, sgn_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] last_q, last_d;
  logic       armed_q, armed_d;
  logic       err_q, err_d;
  logic       step_ok;
  logic       complete;
  logic       malformed;
  logic       busy;
  pulse_t     done_pulse;
  logic [7:0] data_q;

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    last_d    = in;
    complete  = 1'b0;
    malformed = 1'b0;
    // Steps that would wrap past 00/FF are not steps.
    step_ok   = sgn_q ? ((last_q != 8'h00) && (in == last_q - 8'd1))
                      : ((last_q != 8'hFF) && (in == last_q + 8'd1));

    case (state_q)
      IDLE: begin
        if (in == REST) begin
          armed_d = 1'b1;
        end else if (!armed_q) begin
          state_d = IDLE;
        end else if (in == REST + 8'd1) begin
          state_d = RAMP;
          sgn_d   = 1'b0;
          cnt_d   = 7'd1;
        end else if (in == REST - 8'd1) begin
          state_d = RAMP;
          sgn_d   = 1'b1;
          cnt_d   = 7'd1;
        end else begin
          malformed = 1'b1;
          state_d   = RESYNC;
        end
      end
      RAMP: begin
        if (in == REST) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (step_ok && ({1'b0, cnt_q} < HMAX_C)) begin
          cnt_d = cnt_q + 7'd1;
        end else begin
          malformed = 1'b1;
          state_d   = RESYNC;
        end
      end
      RESYNC: begin
        if (in == REST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = malformed || (complete && busy);
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= REST;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign done_pulse = '{s: sgn_q, h: cnt_q};

  dav_producer #(
    .W(8)
  ) u_producer (
    .clock (clock),
    .reset_(reset_),
    .load  (complete),
    .data  (done_pulse),
    .rfd   (rfd),
    .dav_  (dav_),
    .data_q(data_q),
    .busy  (busy)
  );

  assign s   = data_q[7];
  assign h   = data_q[6:0];
  assign err = err_q;

endmodule

// File: tb/tb_triangle_pulse_decoder.sv
// tb/tb_triangle_pulse_decoder.sv - scoreboard bench for the triangle pulse decoder
module tb_triangle_pulse_decoder;

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic [7:0] in = 8'h80;
  logic       rfd = 1'b0;
  logic       s;
  logic [6:0] h;
  logic       dav_;
  logic       err;

  triangle_pulse_decoder dut (
    .clock (clock),
    .reset_(reset_),
    .in    (in),
    .s     (s),
    .h     (h),
    .dav_  (dav_),
    .rfd   (rfd),
    .err   (err)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int edge_n = 0;

  int         err_exp[$];
  int         fall_exp[$];
  int         rise_exp[$];
  logic [7:0] sh_exp[$];

  bit hold_off = 1'b0;
  int cons_wait = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: a pulse is the run of samples between two rest samples,
  // clean iff sample i equals REST + dir*(i+1) and the run is at most 127 long.
  bit m_armed = 1'b0, m_broken = 1'b0, m_full = 1'b0, m_held = 1'b0;
  int seg_len = 0, seg_dir = 0;

  always @(posedge clock) begin
    bit         comp, load, clear;
    logic [7:0] pulse;
    edge_n++;
    comp  = 1'b0;
    load  = 1'b0;
    pulse = 8'h00;
    if (!reset_) begin
      if (m_held) rise_exp.push_back(edge_n);
      m_armed = 1'b0; m_broken = 1'b0; seg_len = 0;
      m_full = 1'b0; m_held = 1'b0;
      sh_exp.delete();
      fall_exp.delete();
    end else begin
      if (!m_armed) begin
        if (in == 8'h80) m_armed = 1'b1;
      end else if (in == 8'h80) begin
        if (seg_len > 0 && !m_broken) begin
          comp  = 1'b1;
          pulse = {seg_dir < 0, 7'(seg_len)};
        end
        seg_len  = 0;
        m_broken = 1'b0;
      end else if (!m_broken) begin
        if (seg_len == 0) seg_dir = (in == 8'h81) ? 1 : (in == 8'h7F) ? -1 : 0;
        if (seg_dir == 0 || seg_len >= 127 || int'(in) != 128 + seg_dir * (seg_len + 1)) begin
          m_broken = 1'b1;
          err_exp.push_back(edge_n);
        end else begin
          seg_len++;
        end
      end

      clear = m_full && m_held && !rfd;
      if (comp) begin
        if (!m_full || clear) load = 1'b1;
        else err_exp.push_back(edge_n);
      end
      if (clear) begin
        m_full = 1'b0; m_held = 1'b0;
        rise_exp.push_back(edge_n);
      end else if (m_full && !m_held && rfd) begin
        m_held = 1'b1;
        fall_exp.push_back(edge_n);
      end
      if (load) begin
        m_full = 1'b1; m_held = 1'b0;
        sh_exp.push_back(pulse);
      end
    end
  end

  // Monitor
  logic       prev_dav = 1'b1;
  logic [7:0] held_sh = 8'h00;

  always @(negedge clock) begin
    logic [7:0] e;
    if (err) begin
      if (err_exp.size() == 0) check("err_unexpected", int'(err), 0);
      else check("err_edge", edge_n, err_exp.pop_front());
    end else if (err_exp.size() > 0 && err_exp[0] <= edge_n) begin
      check("err_missing", int'(err), 1);
      void'(err_exp.pop_front());
    end

    if (prev_dav && !dav_) begin
      if (sh_exp.size() == 0 || fall_exp.size() == 0) begin
        check("dav_fall_unexpected", int'(dav_), 1);
      end else begin
        check("dav_fall_edge", edge_n, fall_exp.pop_front());
        e = sh_exp.pop_front();
        check("s", int'(s), int'(e[7]));
        check("h", int'(h), int'(e[6:0]));
        held_sh = e;
      end
    end else if (!prev_dav && dav_) begin
      if (rise_exp.size() == 0) check("dav_rise_unexpected", int'(dav_), 0);
      else check("dav_rise_edge", edge_n, rise_exp.pop_front());
    end else if (!dav_) begin
      check("sh_stable", int'({s, h}), int'(held_sh));
    end

    if (fall_exp.size() > 0 && fall_exp[0] <= edge_n) begin
      check("dav_fall_missing", int'(dav_), 0);
      void'(fall_exp.pop_front());
      if (sh_exp.size() > 0) void'(sh_exp.pop_front());
    end
    if (rise_exp.size() > 0 && rise_exp[0] <= edge_n) begin
      check("dav_rise_missing", int'(dav_), 1);
      void'(rise_exp.pop_front());
    end
    prev_dav = dav_;
  end

  // Four-phase consumer with random latency; hold_off forces rfd low.
  always @(negedge clock) begin
    if (hold_off) begin
      rfd = 1'b0;
      cons_wait = 0;
    end else if (!rfd && dav_) begin
      if (cons_wait == 0) begin
        rfd = 1'b1;
        cons_wait = $urandom_range(0, 3);
      end else cons_wait--;
    end else if (rfd && !dav_) begin
      if (cons_wait == 0) begin
        rfd = 1'b0;
        cons_wait = $urandom_range(0, 3);
      end else cons_wait--;
    end
  end

  task automatic step(input logic [7:0] x);
    in = x;
    @(negedge clock);
  endtask

  task automatic rest(input int n);
    for (int i = 0; i < n; i++) step(8'h80);
  endtask

  task automatic pulse(input int dir, input int hgt);
    for (int i = 1; i <= hgt; i++) step(8'(128 + dir * i));
    step(8'h80);
  endtask

  task automatic check_reset_state();
    check("rst_dav_", int'(dav_), 1);
    check("rst_err", int'(err), 0);
    check("rst_s", int'(s), 0);
    check("rst_h", int'(h), 0);
  endtask

  initial begin
    int r, n, dir;
    in = 8'h80;
    reset_ = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_state();
    reset_ = 1'b1;
    rest(20);

    pulse(1, 5);   rest(8);
    pulse(-1, 3);  rest(8);
    pulse(1, 1);   rest(8);
    pulse(1, 127); rest(8);

    step(8'h81); step(8'h82); step(8'h82); step(8'h80);
    step(8'h81); step(8'h83); step(8'h80);
    pulse(-1, 1);  rest(10);

    hold_off = 1'b1;
    pulse(1, 2);
    pulse(1, 4);
    rest(3);
    hold_off = 1'b0;
    rest(10);

    hold_off = 1'b1;
    pulse(1, 3);
    step(8'h81); step(8'h82);
    in = 8'h83;
    reset_ = 1'b0;
    @(negedge clock);
    check_reset_state();
    reset_ = 1'b1;
    step(8'h84); step(8'h85); step(8'h80);
    pulse(1, 6);
    hold_off = 1'b0;
    rest(10);

    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
      case (r)
        0, 1, 2, 3, 4, 5: pulse(dir, $urandom_range(1, 12));
        6: pulse(dir, $urandom_range(100, 127));
        7: begin
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) step(8'($urandom_range(0, 255)));
          step(8'h80);
        end
        8: begin
          hold_off = 1'b1;
          rest($urandom_range(2, 10));
          hold_off = 1'b0;
        end
        default: rest($urandom_range(1, 4));
      endcase
    end

    hold_off = 1'b0;
    rest(30);
    check("left_sh", sh_exp.size(), 0);
    check("left_fall", fall_exp.size(), 0);
    check("left_rise", rise_exp.size(), 0);
    check("left_err", err_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
